// File: rtl/or1k_trace_pkg.sv
// -----------------------------------------------------------------------------
// or1k_trace_pkg
// Shared types and constants for the OR1K MPSoC trace/termination monitor.
//   NOP_EXIT / NOP_REPORT / NOP_PUTC : simulation-control l.nop encodings
//   evt_kind_t                      : 2-bit event kind (EXIT, REPORT, PUTC)
//   trace_evt_t                     : event record {core, kind, data}. Its
//                                     fields are sized for the widest
//                                     supported build (256 cores, 64-bit
//                                     data). Narrower builds zero-extend.
//   core_w()                        : width of a core index, minimum 1
// -----------------------------------------------------------------------------
package or1k_trace_pkg;

  localparam logic [31:0] NOP_EXIT   = 32'h1500_0001;
  localparam logic [31:0] NOP_REPORT = 32'h1500_0002;
  localparam logic [31:0] NOP_PUTC   = 32'h1500_0004;

  typedef enum logic [1:0] {
    EVT_EXIT   = 2'd0,
    EVT_REPORT = 2'd1,
    EVT_PUTC   = 2'd2
  } evt_kind_t;

  localparam int EVT_CORE_W = 8;
  localparam int EVT_DATA_W = 64;

  typedef struct packed {
    logic [EVT_CORE_W-1:0] core;
    evt_kind_t             kind;
    logic [EVT_DATA_W-1:0] data;
  } trace_evt_t;

  function automatic int core_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/or1k_trace_event_fifo.sv
// -----------------------------------------------------------------------------
// or1k_trace_event_fifo
// Per-core synchronous event FIFO. DEPTH must be a power of 2 and at least 2.
// A push to a full FIFO is accepted when a pop happens in the same cycle.
// A pop on an empty FIFO is ignored.
// Ports:
//   clk, rst_n        clock, async active-low reset (empties the FIFO)
//   push, push_data   write request and word
//   pop               consume the head word
//   head              current head word (valid when !empty)
//   full, empty       status flags
// -----------------------------------------------------------------------------
module or1k_trace_event_fifo
  import or1k_trace_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/or1k_mpsoc_term_monitor.sv
// -----------------------------------------------------------------------------
// or1k_mpsoc_term_monitor
// Multi-core trace and termination monitor. It decodes the l.nop EXIT,
// REPORT and PUTC codes from each core's retire port and queues them per
// core. A round-robin arbiter merges the queues into one registered event
// stream. The block also tracks per-core and global termination and counts
// cycles until every core has exited.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   trace_valid/insn/r3            per-core retire port (core i at slice i)
//   evt_valid/ready/core/kind/data event stream, valid/ready handshake
//   term, all_term                 per-core and global termination
//   overflow                       sticky per-core event-dropped flag
//   cycle_cnt                      saturating cycles since reset, frozen at all_term
//   timeout                        sticky watchdog flag
// Optional feature macro: OR1K_TERM_WATCHDOG_EN. It builds an idle counter
// that sets `timeout` when there are no retirements for TIMEOUT_CYCLES
// cycles. When the macro is undefined, `timeout` is tied to 0.
// -----------------------------------------------------------------------------
module or1k_mpsoc_term_monitor
  import or1k_trace_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int CORE_W        = core_w(NUM_CORES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CORES-1:0]             trace_valid,
  input  logic [NUM_CORES*32-1:0]          trace_insn,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  trace_r3,
  output logic                             evt_valid,
  input  logic                             evt_ready,
  output logic [CORE_W-1:0]                evt_core,
  output logic [1:0]                       evt_kind,
  output logic [DATA_WIDTH-1:0]            evt_data,
  output logic [NUM_CORES-1:0]             term,
  output logic                             all_term,
  output logic [NUM_CORES-1:0]             overflow,
  output logic [CNT_WIDTH-1:0]             cycle_cnt,
  output logic                             timeout
);

  // FIFO word: {kind, data}. The core is implied by which FIFO holds it.
  localparam int FW = 2 + DATA_WIDTH;

  logic [NUM_CORES-1:0]          qual, dec_push, exit_hit, ovf_set;
  logic [NUM_CORES-1:0][FW-1:0]  dec_word, fifo_head;
  logic [NUM_CORES-1:0]          fifo_full, fifo_empty, fifo_pop;

  logic                          load, win_found;
  logic [CORE_W-1:0]             win_idx, rr_ptr, cand;
  logic [CORE_W:0]               sum;
  logic [FW-1:0]                 win_word;
  logic                          evt_valid_q;
  trace_evt_t                    evt_q;
  logic                          unused_evt;

  // ---------------- per-core decode + queue ----------------
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic [31:0]           insn;
    logic [DATA_WIDTH-1:0] r3;
    logic                  is_exit, is_rep, is_putc;

    assign insn    = trace_insn[32*g +: 32];
    assign r3      = trace_r3[DATA_WIDTH*g +: DATA_WIDTH];
    assign is_exit = (insn == NOP_EXIT);
    assign is_rep  = (insn == NOP_REPORT);
    assign is_putc = (insn == NOP_PUTC);

    assign qual[g]     = trace_valid[g] & ~term[g];
    assign dec_push[g] = qual[g] & (is_exit | is_rep | is_putc);
    assign exit_hit[g] = qual[g] & is_exit;
    assign dec_word[g] = is_putc ? {EVT_PUTC, DATA_WIDTH'(r3[7:0])}
                                 : {(is_exit ? EVT_EXIT : EVT_REPORT), r3};
    // Dropped only if full and not being drained this same cycle.
    assign ovf_set[g]  = dec_push[g] & fifo_full[g] & ~fifo_pop[g];

    or1k_trace_event_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (dec_push[g]),
      .push_data (dec_word[g]),
      .pop       (fifo_pop[g]),
      .head      (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  // ---------------- round-robin arbiter ----------------
  // Scan from rr_ptr upward with wrap. sum < 2*NUM_CORES, so one subtract
  // is enough to bring it back into range.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int off = 0; off < NUM_CORES; off++) begin
      sum = {1'b0, rr_ptr} + (CORE_W+1)'(off);
      if (sum >= (CORE_W+1)'(NUM_CORES)) sum = sum - (CORE_W+1)'(NUM_CORES);
      cand = sum[CORE_W-1:0];
      if (!win_found && !fifo_empty[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign load     = ~evt_valid_q | evt_ready;
  assign win_word = fifo_head[win_idx];

  always_comb begin
    fifo_pop = '0;
    if (load && win_found) fifo_pop[win_idx] = 1'b1;
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      evt_valid_q <= win_found;
      if (win_found) begin
        evt_q.core <= EVT_CORE_W'(win_idx);
        evt_q.kind <= evt_kind_t'(win_word[FW-1 -: 2]);
        evt_q.data <= EVT_DATA_W'(win_word[DATA_WIDTH-1:0]);
        rr_ptr     <= (win_idx == CORE_W'(NUM_CORES-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_core   = evt_q.core[CORE_W-1:0];
  assign evt_kind   = evt_q.kind;
  assign evt_data   = evt_q.data[DATA_WIDTH-1:0];
  // The record is sized for the widest build. The extra high bits stay zero.
  assign unused_evt = ^evt_q;

  // ---------------- termination + cycle count ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term      <= '0;
      all_term  <= 1'b0;
      overflow  <= '0;
      cycle_cnt <= '0;
    end else begin
      term     <= term | exit_hit;
      all_term <= &(term | exit_hit);
      overflow <= overflow | ovf_set;
      if (!all_term && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  // ---------------- optional watchdog ----------------
`ifdef OR1K_TERM_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt, idle_nxt;
  logic          timeout_q;

  always_comb begin
    idle_nxt = idle_cnt;
    if (|qual)
      idle_nxt = '0;
    else if (!all_term && idle_cnt != TW'(TIMEOUT_CYCLES))
      idle_nxt = idle_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_cnt <= idle_nxt;
      if (idle_nxt == TW'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  localparam bit unused_wd_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

endmodule
